// File: rtl/csa_stream_accumulator_if.sv
// Operand-in / result-out handshake bundle for csa_stream_accumulator.
//   in_valid/in_ready/in_data/in_last : operand stream into the accumulator
//   out_valid/out_ready/out_data/out_overflow/out_count : resolved result stream
// The slave modport is the accumulator's view; the master modport is the source/sink view.
interface csa_stream_accumulator_if #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned ACC_W   = 36,
  parameter int unsigned COUNT_W = 16
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic [ACC_W-1:0]   out_data;
  logic               out_overflow;
  logic [COUNT_W-1:0] out_count;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_overflow, out_count
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_overflow, out_count
  );
endinterface

// File: rtl/csa_stream_accumulator.sv
// Carry-save multi-operand accumulator. Each accepted operand is folded into a
// redundant sum/carry pair with one 3:2 stage; the last operand triggers a single
// carry-propagate add whose result is held behind a valid/ready handshake.
//   clock : rising-edge clock
//   reset : synchronous, active-high; aborts a packet and drops a pending result
//   bus   : slave side of csa_stream_accumulator_if (operand in, result out)
// Bus parameters must be WIDTH, WIDTH+GUARD and COUNT_W respectively.
module csa_stream_accumulator #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned GUARD   = 4,
  parameter bit          SIGNED  = 1'b0,
  parameter int unsigned COUNT_W = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  csa_stream_accumulator_if.slave bus
);

  localparam int unsigned ACC_W = WIDTH + GUARD;
  localparam int unsigned SUM_W = ACC_W + 1;
  // Bits above the operand width, set when sign-extending a negative operand.
  localparam logic [ACC_W-1:0] EXT_MASK = ~((ACC_W'(1) << WIDTH) - ACC_W'(1));

  typedef enum logic [1:0] {
    ST_ACCUM   = 2'd0,
    ST_RESOLVE = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   s_q, s_d;
  logic [ACC_W-1:0]   c_q, c_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [ACC_W-1:0]   out_data_q, out_data_d;
  logic               out_ovf_q, out_ovf_d;
  logic [COUNT_W-1:0] out_count_q, out_count_d;

  logic [ACC_W-1:0]   x;
  logic [ACC_W-1:0]   maj;
  logic [ACC_W-1:0]   sum;
  logic               cout;
  logic [COUNT_W-1:0] count_inc;
  logic               guard_exceeded;

  // State and datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_ACCUM;
      s_q         <= '0;
      c_q         <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      c_q         <= c_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
      out_count_q <= out_count_d;
    end
  end

  // Next-state, carry-save fold, final resolve and handshake outputs.
  always_comb begin
    x = ACC_W'(bus.in_data);
    if (SIGNED && bus.in_data[WIDTH-1]) begin
      x = x | EXT_MASK;
    end
    maj            = (s_q & c_q) | (s_q & x) | (c_q & x);
    {cout, sum}    = SUM_W'(s_q) + SUM_W'(c_q);
    count_inc      = (count_q == '1) ? count_q : count_q + COUNT_W'(1);
    // Signed mode cannot track wrap exactly; flag once the guard headroom is exceeded.
    guard_exceeded = 64'(count_q) > (64'(1) << GUARD);

    state_d     = state_q;
    s_d         = s_q;
    c_d         = c_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    out_count_d = out_count_q;

    unique case (state_q)
      ST_ACCUM: begin
        if (bus.in_valid && in_ready_q) begin
          s_d     = s_q ^ c_q ^ x;
          // Shifted-out top carry is a real overflow of the unsigned sum.
          c_d     = maj << 1;
          ovf_d   = ovf_q | maj[ACC_W-1];
          count_d = count_inc;
          if (bus.in_last) begin
            state_d = ST_RESOLVE;
          end
        end
      end
      ST_RESOLVE: begin
        out_data_d  = sum;
        out_count_d = count_q;
        out_ovf_d   = SIGNED ? guard_exceeded : (ovf_q | cout);
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        if (out_valid_q && bus.out_ready) begin
          s_d     = '0;
          c_d     = '0;
          count_d = '0;
          ovf_d   = 1'b0;
          state_d = ST_ACCUM;
        end
      end
      default: begin
        state_d = ST_ACCUM;
      end
    endcase

    in_ready_d  = (state_d == ST_ACCUM);
    out_valid_d = (state_d == ST_DONE);
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_q;
  assign bus.out_overflow = out_ovf_q;
  assign bus.out_count    = out_count_q;

endmodule
